sigmoid_pwl_pipe: RTL and testbench
===================================

# sigmoid_pwl_pipe

Pipelined piecewise-linear sigmoid unit for the VAE activation path. It accepts signed Q8.8 pre-activations with a valid/ready handshake. It evaluates the positive-half approximation on |x| and produces the segment value that the reflection step consumes. For negative inputs it applies that reflection, 1.0 − y, computed as the one's complement of y plus 0x0101. Output is Q8.8 in [0x0000, 0x0100], three cycles after acceptance.

## Interface
- No parameters. Format is fixed at 16-bit Q8.8 two's complement (8 fractional bits).
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  16  x, signed Q8.8
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  16  sigmoid(x), Q8.8, never negative, max 0x0100

## Operation
- Segments on a = |x|. Shifts are logical right shifts with truncation. Q8.8 constants:
  - a ≥ 0x0500 (5.0): y = 0x0100
  - 0x0260 ≤ a < 0x0500: y = (a >> 5) + 0x00D8
  - 0x0100 ≤ a < 0x0260: y = (a >> 3) + 0x00A0
  - a < 0x0100: y = (a >> 2) + 0x0080
- |x|:
  - x ≥ 0: a = x.
  - x < 0: a = ~x + 1.
  - x = 0x8000: a saturates to 0x7FFF, so y = 0x0100.
- Sign: x ≥ 0 outputs y. x < 0 outputs (~y) + 0x0101 mod 2^16, which equals 0x0100 − y.
- Intermediate sums are computed at 16 bits. No segment can overflow (max y = 0x0100).
- Stage S1: latch x, sign bit, a.
- Stage S2: compare a against 0x0500/0x0260/0x0100, select shift and offset, latch y and sign.
- Stage S3: conditional reflection, latch out_data and out_valid.
- Each stage holds a valid bit.
- Global stall: adv = out_ready | ~out_valid. in_ready = adv (combinational).
- When adv = 1, all stages shift one step, and S1 captures (in_valid & in_ready).
- When adv = 0, every stage register holds.
- Bubbles are not collapsed. An empty middle stage while S3 is stalled still stalls the input.
- Transfer occurs on (valid & ready) at a clock edge, both sides.

## Timing
- Reset, synchronous:
  - All stage valid bits clear.
  - out_valid = 0 and out_data = 0x0000.
  - in_ready = 1 in the cycle after reset, since out_valid = 0.
  - Inputs presented while rst = 1 are discarded.
- Latency: a sample accepted at edge N appears with out_valid = 1 after edge N+3, given no stall.
- Throughput: one sample per cycle while out_ready = 1.
- out_data and out_valid are stable while out_valid = 1 and out_ready = 0.
- Input acceptance is not dependent on in_valid. in_ready depends only on out_valid and out_ready.
- Reset mid-operation drops all in-flight samples. No output for them appears after reset is released.
- Samples are never dropped, duplicated or reordered. Order out equals order in.
- When out_ready is deasserted while S3 is valid:
  - in_ready falls in the same cycle.
  - A sample offered that cycle is not accepted and must be held by the source.

## Test plan
- Reset then single samples, each giving out_data 3 cycles later:
  - 0x0000 → 0x0080
  - 0x00FF → 0x00BF
  - 0x0100 → 0x00C0
  - 0x0300 → 0x00F0
  - 0x0600 → 0x0100
- Negative reflection:
  - 0xFF00 (−1.0) → 0x0040
  - 0xFD00 (−3.0) → 0x0010
  - 0x8000 → 0x0000
  - 0xFFFF (−1 LSB) → 0x0080
- Breakpoints:
  - 0x025F → 0x00EB, 0x0260 → 0x00EB
  - 0x04FF → 0x00FF, 0x0500 → 0x0100
  - Also sweep all 65536 inputs against a reference model: output ≤ 0x0100, and sigmoid(x) + sigmoid(−x) = 0x0100 for x ≠ 0x8000.
- Streaming: 10 back-to-back samples with out_ready = 1 → 10 outputs on consecutive cycles, in order, first at cycle 3.
- Backpressure: stream while toggling out_ready randomly (≈50%).
  - in_ready = 0 exactly when out_valid = 1 and out_ready = 0.
  - out_data is stable while stalled.
  - No loss or duplication against a scoreboard.
- Reset mid-stream: 3 samples in flight, assert rst for 1 cycle.
  - out_valid = 0 next cycle.
  - None of the 3 samples ever emerges.
  - A new sample after reset appears 3 cycles after acceptance.

Source files
------------

// File: rtl/sigmoid_pwl_pipe_if.sv
// rtl/sigmoid_pwl_pipe_if.sv - valid/ready input and output streams of the sigmoid pipeline
interface sigmoid_pwl_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sigmoid_pwl_pipe.sv
// rtl/sigmoid_pwl_pipe.sv - pipelined piecewise-linear sigmoid on signed Q8.8 samples
// Accept register, then S1 |x|, S2 segment value, S3 reflection; one global stall.
module sigmoid_pwl_pipe (
  input logic               clk,
  input logic               rst,
  sigmoid_pwl_pipe_if.slave bus
);
  logic        adv;
  logic        s0_valid;
  logic [15:0] s0_x;
  logic        s1_valid;
  logic        s1_neg;
  logic [15:0] s1_abs;
  logic        s2_valid;
  logic        s2_neg;
  logic [15:0] s2_y;
  logic        s3_valid;
  logic [15:0] s3_data;
  logic [15:0] abs_c;
  logic [15:0] y_c;

  // Every stage moves together; a bubble in the middle never lets the input run ahead.
  assign adv          = bus.out_ready | ~s3_valid;
  assign bus.in_ready = adv;
  assign bus.out_valid = s3_valid;
  assign bus.out_data  = s3_data;

  always_comb begin
    abs_c = s0_x;
    if (s0_x == 16'h8000) begin
      abs_c = 16'h7FFF;
    end else if (s0_x[15]) begin
      abs_c = ~s0_x + 16'h0001;
    end
  end

  always_comb begin
    y_c = 16'h0100;
    if (s1_abs < 16'h0100) begin
      y_c = (s1_abs >> 2) + 16'h0080;
    end else if (s1_abs < 16'h0260) begin
      y_c = (s1_abs >> 3) + 16'h00A0;
    end else if (s1_abs < 16'h0500) begin
      y_c = (s1_abs >> 5) + 16'h00D8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_x     <= 16'h0000;
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_abs   <= 16'h0000;
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_y     <= 16'h0000;
      s3_valid <= 1'b0;
      s3_data  <= 16'h0000;
    end else if (adv) begin
      s0_valid <= bus.in_valid;
      s0_x     <= bus.in_data;
      s1_valid <= s0_valid;
      s1_neg   <= s0_x[15];
      s1_abs   <= abs_c;
      s2_valid <= s1_valid;
      s2_neg   <= s1_neg;
      s2_y     <= y_c;
      s3_valid <= s2_valid;
      // 1.0 - y for negative inputs, as one's complement plus 0x0101
      s3_data  <= s2_valid ? (s2_neg ? (~s2_y + 16'h0101) : s2_y) : 16'h0000;
    end
  end
endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// tb/tb_sigmoid_pwl_pipe.sv - scoreboard bench for sigmoid_pwl_pipe
module tb_sigmoid_pwl_pipe;
  typedef struct {
    logic [15:0] x;
    logic [15:0] exp;
    int          acc;
    bit          lat;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   bp_on = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  item_t sb[$];
  logic [15:0] res [0:65535];

  sigmoid_pwl_pipe_if bus ();

  sigmoid_pwl_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] ref_sig(input logic [15:0] x);
    int v, a, y;
    v = int'($signed(x));
    a = (v < 0) ? -v : v;
    if (a > 32767) a = 32767;
    if (a >= 1280)     y = 256;
    else if (a >= 608) y = a / 32 + 216;
    else if (a >= 256) y = a / 8 + 160;
    else               y = a / 4 + 128;
    return (v < 0) ? 16'(256 - y) : 16'(y);
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    item_t it;
    bit prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      check(bus.in_ready == (bus.out_ready | ~bus.out_valid), "in_ready_rule",
            bus.in_ready, bus.out_ready | ~bus.out_valid);
      if (prev_stall)
        check(bus.out_valid && bus.out_data == prev_data, "stall_hold", bus.out_data, prev_data);
      if (bus.out_valid) begin
        check(bus.out_data <= 16'h0100, "range", bus.out_data, 16'h0100);
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            check(1'b0, "unexpected_out", bus.out_data, 0);
          end else begin
            it = sb.pop_front();
            check(bus.out_data == it.exp, "data", bus.out_data, it.exp);
            res[it.x] = bus.out_data;
            if (it.lat) check(cyc - it.acc == 3, "latency", cyc - it.acc, 3);
          end
        end
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] exp, input bit lat);
    item_t it;
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        it.x = x; it.exp = exp; it.acc = cyc + 1; it.lat = lat;
        sb.push_back(it);
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check(1'b0, "accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) check(1'b0, "drain_timeout", sb.size(), 0);
  endtask

  initial begin
    logic [15:0] dx [13];
    logic [15:0] dy [13];
    logic [15:0] r;
    int sum;
    dx = '{16'h0000, 16'h00FF, 16'h0100, 16'h0300, 16'h0600, 16'hFF00, 16'hFD00,
           16'h8000, 16'hFFFF, 16'h025F, 16'h0260, 16'h04FF, 16'h0500};
    dy = '{16'h0080, 16'h00BF, 16'h00C0, 16'h00F0, 16'h0100, 16'h0040, 16'h0010,
           16'h0000, 16'h0080, 16'h00EB, 16'h00EB, 16'h00FF, 16'h0100};
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check(bus.out_valid == 1'b0, "reset_out_valid", bus.out_valid, 0);
    check(bus.out_data == 16'h0000, "reset_out_data", bus.out_data, 0);
    check(bus.in_ready == 1'b1, "reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      send(dx[i], dy[i], 1'b1);
      drain();
    end

    for (int i = 0; i < 10; i++) begin
      r = 16'($urandom);
      send(r, ref_sig(r), 1'b1);
    end
    drain();

    bp_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = 16'($urandom);
      send(r, ref_sig(r), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bp_on = 1'b0;
    drain();

    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom);
      send(r, ref_sig(r), 1'b1);
    end
    rst = 1'b1;
    sb.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check(bus.out_valid == 1'b0, "midreset_out_valid", bus.out_valid, 0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    send(16'hFF00, 16'h0040, 1'b1);
    drain();

    for (int i = 0; i < 65536; i++) begin
      r = 16'(i);
      send(r, ref_sig(r), 1'b1);
    end
    drain();
    for (int i = 0; i < 65536; i++) begin
      if (i != 32768) begin
        r = 16'(65536 - i);
        sum = int'(res[i]) + int'(res[r]);
        check(sum == 256, "symmetry", sum, 256);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
